// File: rtl/maindec_pkg.sv
// Shared opcodes, select encodings and the control bundle carried down the
// maindec_pipe pipeline.
package maindec_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        imm_src_t    imm_src;
        alu_src_a_t  alu_src_a;
        logic        alu_src;
        logic        dmem_write;
        result_src_t result_src;
        logic        branch;
        logic [1:0]  alu_op;
        logic        jump;
        logic        jalr;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/maindec_decode.sv
// Combinational opcode -> control bundle decode; unknown opcodes give a
// bubble and raise illegal_d.
module maindec_decode
    import maindec_pkg::*;
(
    input  logic [6:0] op_d,
    output ctrl_t      ctrl_d,
    output logic       illegal_d
);

    always_comb begin
        ctrl_d    = CTRL_BUBBLE;
        illegal_d = 1'b0;
        case (op_d)
            OP_LW:     ctrl_d = '{1'b1, IMM_I, SRCA_RS1,  1'b1, 1'b0, RES_MEM, 1'b0, ALU_ADD,   1'b0, 1'b0};
            OP_SW:     ctrl_d = '{1'b0, IMM_S, SRCA_RS1,  1'b1, 1'b1, RES_ALU, 1'b0, ALU_ADD,   1'b0, 1'b0};
            OP_R:      ctrl_d = '{1'b1, IMM_I, SRCA_RS1,  1'b0, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0};
            OP_BRANCH: ctrl_d = '{1'b0, IMM_B, SRCA_RS1,  1'b0, 1'b0, RES_ALU, 1'b1, ALU_SUB,   1'b0, 1'b0};
            OP_IALU:   ctrl_d = '{1'b1, IMM_I, SRCA_RS1,  1'b1, 1'b0, RES_ALU, 1'b0, ALU_FUNCT, 1'b0, 1'b0};
            OP_JAL:    ctrl_d = '{1'b1, IMM_J, SRCA_RS1,  1'b0, 1'b0, RES_PC4, 1'b0, ALU_ADD,   1'b1, 1'b0};
            OP_JALR:   ctrl_d = '{1'b1, IMM_I, SRCA_RS1,  1'b1, 1'b0, RES_PC4, 1'b0, ALU_ADD,   1'b1, 1'b1};
            OP_LUI:    ctrl_d = '{1'b1, IMM_U, SRCA_ZERO, 1'b1, 1'b0, RES_ALU, 1'b0, ALU_ADD,   1'b0, 1'b0};
            OP_AUIPC:  ctrl_d = '{1'b1, IMM_U, SRCA_PC,   1'b1, 1'b0, RES_ALU, 1'b0, ALU_ADD,   1'b0, 1'b0};
            default:   illegal_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/maindec_pipe.sv
// Pipelined main decoder: D-stage decode registered through E, M and W with
// stall/flush bubbles. Define MAINDEC_ILLEGAL_TRAP_EN for illegal_e/illegal_count.
module maindec_pipe
    import maindec_pkg::*;
#(
    parameter int IMM_SRC_W = 3,
    parameter int ALU_OP_W  = 2,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 stall_m,
    output logic                 reg_write_e,
    output logic                 alu_src_e,
    output logic                 dmem_write_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic [IMM_SRC_W-1:0] imm_src_e,
    output logic [1:0]           alu_src_a_e,
    output logic [ALU_OP_W-1:0]  alu_op_e,
    output logic [1:0]           result_src_e,
    output logic                 reg_write_m,
    output logic                 dmem_write_m,
    output logic [1:0]           result_src_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic                 illegal_d
`ifdef MAINDEC_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_e,
    output logic [COUNT_W-1:0]   illegal_count
`endif
);

    ctrl_t       ctrl_d;
    ctrl_t       ctrl_e_p0;
    logic        reg_write_m_p1;
    logic        dmem_write_m_p1;
    result_src_t result_src_m_p1;
    logic        reg_write_w_p2;
    result_src_t result_src_w_p2;
    logic        load_e;
    logic        bubble_m;

    maindec_decode u_decode (
        .op_d      (op_d),
        .ctrl_d    (ctrl_d),
        .illegal_d (illegal_d)
    );

    assign load_e = !flush_e && !stall_e && !stall_m;
    // A flushed E slot lets its old occupant advance, so only an unflushed stall_e starves M.
    assign bubble_m = stall_e && !flush_e;

    // D -> E
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_e_p0 <= CTRL_BUBBLE;
        end else if (flush_e) begin
            ctrl_e_p0 <= CTRL_BUBBLE;
        end else if (load_e) begin
            ctrl_e_p0 <= ctrl_d;
        end
    end

    // E -> M
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_m_p1  <= 1'b0;
            dmem_write_m_p1 <= 1'b0;
            result_src_m_p1 <= RES_ALU;
        end else if (!stall_m) begin
            if (bubble_m) begin
                reg_write_m_p1  <= 1'b0;
                dmem_write_m_p1 <= 1'b0;
                result_src_m_p1 <= RES_ALU;
            end else begin
                reg_write_m_p1  <= ctrl_e_p0.reg_write;
                dmem_write_m_p1 <= ctrl_e_p0.dmem_write;
                result_src_m_p1 <= ctrl_e_p0.result_src;
            end
        end
    end

    // M -> W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_w_p2  <= 1'b0;
            result_src_w_p2 <= RES_ALU;
        end else if (stall_m) begin
            reg_write_w_p2  <= 1'b0;
            result_src_w_p2 <= RES_ALU;
        end else begin
            reg_write_w_p2  <= reg_write_m_p1;
            result_src_w_p2 <= result_src_m_p1;
        end
    end

    assign reg_write_e  = ctrl_e_p0.reg_write;
    assign alu_src_e    = ctrl_e_p0.alu_src;
    assign dmem_write_e = ctrl_e_p0.dmem_write;
    assign branch_e     = ctrl_e_p0.branch;
    assign jump_e       = ctrl_e_p0.jump;
    assign jalr_e       = ctrl_e_p0.jalr;
    assign imm_src_e    = IMM_SRC_W'(ctrl_e_p0.imm_src);
    assign alu_src_a_e  = ctrl_e_p0.alu_src_a;
    assign alu_op_e     = ALU_OP_W'(ctrl_e_p0.alu_op);
    assign result_src_e = ctrl_e_p0.result_src;
    assign reg_write_m  = reg_write_m_p1;
    assign dmem_write_m = dmem_write_m_p1;
    assign result_src_m = result_src_m_p1;
    assign reg_write_w  = reg_write_w_p2;
    assign result_src_w = result_src_w_p2;

`ifdef MAINDEC_ILLEGAL_TRAP_EN
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    logic               illegal_e_p0;
    logic [COUNT_W-1:0] illegal_count_q;

    // D -> E (illegal tag and counter)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_e_p0    <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            if (flush_e) begin
                illegal_e_p0 <= 1'b0;
            end else if (load_e) begin
                illegal_e_p0 <= illegal_d;
            end
            if (load_e && illegal_d) begin
                illegal_count_q <= sat_inc(illegal_count_q);
            end
        end
    end

    assign illegal_e     = illegal_e_p0;
    assign illegal_count = illegal_count_q;
`endif

endmodule

// File: doc/maindec_pipe.md
# maindec_pipe

Pipelined main control unit for the five-stage RV32I core. Decodes the Decode-stage opcode into the non-ALU control bundle and carries it through the E, M and W pipeline registers, honouring the hazard unit's stall and flush requests. Compared with the single-cycle decoder it adds lui, auipc and jalr, widens the immediate and ALU-operand selects, and inserts bubbles on stalls and flushes. It sits between the D-stage instruction register and the datapath/hazard unit.

## Interface
- IMM_SRC_W, 3, width of imm_src; must be ≥ 3.
- ALU_OP_W, 2, width of alu_op; upper bits beyond 2 are driven 0.
- COUNT_W, 16, width of illegal_count (used only with the macro).

- clk  in  1  core clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_d  in  7  opcode of the D-stage instruction.
- stall_e  in  1  hold the E register.
- flush_e  in  1  load a bubble into the E register.
- stall_m  in  1  hold the E and M registers.
- reg_write_e, alu_src_e, dmem_write_e, branch_e, jump_e, jalr_e  out  1 each  E-stage controls.
- imm_src_e  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U.
- alu_src_a_e  out  2  00 rs1, 01 pc, 10 zero.
- alu_op_e  out  ALU_OP_W  00 add, 01 sub/branch, 10 funct-decoded.
- result_src_e  out  2  00 ALU, 01 memory, 10 pc+4.
- reg_write_m, dmem_write_m  out  1  M-stage controls.
- result_src_m  out  2  M-stage result select.
- reg_write_w  out  1  W-stage register write enable.
- result_src_w  out  2  W-stage result select.
- illegal_d  out  1  combinational; op_d is not a supported opcode.
- illegal_e  out  1  macro only; E holds an illegal instruction.
- illegal_count  out  COUNT_W  macro only; saturating count of illegal opcodes.

## Operation
- **Decode** is combinational. Each bundle below is {reg_write, imm_src, alu_src_a, alu_src, dmem_write, result_src, branch, alu_op, jump, jalr}:
  - lw 0000011: 1, I, 00, 1, 0, 01, 0, 00, 0, 0
  - sw 0100011: 0, S, 00, 1, 1, 00, 0, 00, 0, 0
  - R 0110011: 1, I, 00, 0, 0, 00, 0, 10, 0, 0
  - branch 1100011: 0, B, 00, 0, 0, 00, 1, 01, 0, 0
  - I-ALU 0010011: 1, I, 00, 1, 0, 00, 0, 10, 0, 0
  - jal 1101111: 1, J, 00, 0, 0, 10, 0, 00, 1, 0
  - jalr 1100111: 1, I, 00, 1, 0, 10, 0, 00, 1, 1
  - lui 0110111: 1, U, 10, 1, 0, 00, 0, 00, 0, 0
  - auipc 0010111: 1, U, 01, 1, 0, 00, 0, 00, 0, 0
  - Any other opcode produces the all-zero bundle and asserts illegal_d.
- **Bubble** is the all-zero bundle; it writes nothing, stores nothing and never branches.
- **E register**, in priority order:
  - flush_e loads a bubble. flush_e beats both stalls.
  - stall_e or stall_m holds the register.
  - Otherwise it loads the decode of op_d.
- **M register**:
  - stall_m holds the register.
  - stall_e alone loads a bubble.
  - Otherwise it loads from E.
- **W register**:
  - stall_m loads a bubble.
  - Otherwise it loads from M.

## Timing
- Reset value of every registered output is 0, and illegal_count is 0. Reset applies asynchronously and releases on the first clock edge after reset_n goes high.
- Latency: op_d decoded in cycle n appears on *_e in n+1, *_m in n+2, *_w in n+3, absent stalls.
- Reset asserted mid-stream clears all three registers immediately; in-flight instructions are dropped.
- Flush and stall are sampled only at clock edges; the outputs never depend combinationally on them.

## Configuration
- MAINDEC_ILLEGAL_TRAP_EN defined:
  - illegal_e is carried in the E register, with the same flush and stall rules as the bundle.
  - illegal_count increments on each edge where the E register loads a decoded (non-flushed, non-held) illegal opcode.
  - illegal_count saturates at 2^COUNT_W−1.
- Undefined: illegal_e and illegal_count are absent. Illegal opcodes flow as silent bubbles, and illegal_d remains.

## Structure
- maindec_pkg holds:
  - opcode localparams;
  - imm_src, alu_src_a and result_src enums;
  - ctrl_t, the packed control bundle struct;
  - CTRL_BUBBLE, the all-zero ctrl_t constant.
- One sub-module, maindec_decode, contains the combinational opcode → ctrl_t decode plus illegal_d. maindec_pipe instantiates it and owns the three pipeline registers.

## Test plan
- **Reset:** reset_n=0 with op_d=lw → all outputs 0. Release, then hold op_d=lw → reg_write_e=1 and result_src_e=01 one edge later, reg_write_w=1 three edges later.
- **New opcodes:** op_d=lui → imm_src_e=100, alu_src_a_e=10. op_d=auipc → alu_src_a_e=01. op_d=jalr → jump_e=1, jalr_e=1, result_src_e=10.
- **Flush priority:** E holds sw; apply flush_e=1 and stall_e=1 together → dmem_write_e=0 next cycle, and sw advances to M (dmem_write_m=1).
- **stall_m:** E=lw, M=R-type; stall_m=1 for 2 cycles → *_e and *_m unchanged, reg_write_w=0 both cycles, then the R-type reaches W.
- **Illegal opcode (macro):** op_d=0000000 → illegal_d=1, bundle zero, illegal_e=1 next cycle. With COUNT_W=2, 5 unflushed illegals → count 3.
- **Mid-stream reset:** jal in M, reset_n pulsed low between edges → reg_write_m and result_src_m drop to 0 without a clock edge.
